// File: rtl/fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit
//
// Forwarding and load-use hazard control for the pipelined 64-bit LEGv8
// datapath. The block keeps its own copy of the register tags for the
// instructions in ID/EX, EX/MEM and MEM/WB. From these tags it drives the
// select lines of the two EX-stage operand 4:1 muxes. It also raises a
// one-cycle load-use stall and counts the stall cycles.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   id_valid     decode slot holds a real instruction
//   id_rn/id_rm  decode source registers A/B
//   id_use_rn    decode instruction reads rn
//   id_use_rm    decode instruction reads rm
//   id_use_imm   decode operand B comes from the immediate
//   id_rd        decode destination register
//   id_regwrite  decode instruction writes rd
//   id_memread   decode instruction is a load
//   flush        branch taken: squash the decode slot
//   fwd_a_sel    operand A select (00 RF, 01 EX/MEM, 10 MEM/WB)
//   fwd_b_sel    operand B select (as A, plus 11 immediate)
//   stall        hold PC and IF/ID, insert a bubble into ID/EX
//   stall_count  saturating count of stall cycles
// ---------------------------------------------------------------------------
module fwd_hazard_unit #(
  parameter int REG_W    = 5,
  parameter int ZERO_REG = 31,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic             id_use_imm,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EXM = 2'b01;
  localparam logic [1:0] SEL_MWB = 2'b10;
  localparam logic [1:0] SEL_IMM = 2'b11;

  // ID/EX tags
  logic             idex_valid_q,    idex_valid_d;
  logic [REG_W-1:0] idex_rn_q,       idex_rn_d;
  logic [REG_W-1:0] idex_rm_q,       idex_rm_d;
  logic             idex_use_rn_q,   idex_use_rn_d;
  logic             idex_use_rm_q,   idex_use_rm_d;
  logic             idex_use_imm_q,  idex_use_imm_d;
  logic [REG_W-1:0] idex_rd_q,       idex_rd_d;
  logic             idex_regwrite_q, idex_regwrite_d;
  logic             idex_memread_q,  idex_memread_d;

  // EX/MEM tags
  logic             exmem_valid_q;
  logic [REG_W-1:0] exmem_rd_q;
  logic             exmem_regwrite_q;
  logic             exmem_memread_q;

  // MEM/WB tags
  logic             memwb_valid_q;
  logic [REG_W-1:0] memwb_rd_q;
  logic             memwb_regwrite_q;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             load_in_ex;
  logic             rn_hit, rm_hit;
  logic             exm_fwd_ok, mwb_fwd_ok;
  logic             a_exm, a_mwb, b_exm, b_mwb;
  logic             take;

  // Load-use detection: the decode instruction reads the destination of a
  // load that is currently in EX. Operand B taken from the immediate does not
  // read rm, so it cannot create a hazard.
  always_comb begin
    load_in_ex = idex_valid_q & idex_memread_q & idex_regwrite_q & (idex_rd_q != ZR);
    rn_hit     = id_use_rn & (id_rn == idex_rd_q);
    rm_hit     = id_use_rm & ~id_use_imm & (id_rm == idex_rd_q);
    stall      = id_valid & load_in_ex & (rn_hit | rm_hit);
  end

  // Operand selects come from registered tags only. A load sitting in EX/MEM
  // has no data yet, so it is excluded there. The stall guarantees that such
  // a load is picked up from MEM/WB one cycle later.
  always_comb begin
    exm_fwd_ok = exmem_valid_q & exmem_regwrite_q & ~exmem_memread_q;
    mwb_fwd_ok = memwb_valid_q & memwb_regwrite_q;

    a_exm = idex_use_rn_q & exm_fwd_ok & (exmem_rd_q == idex_rn_q) & (idex_rn_q != ZR);
    a_mwb = idex_use_rn_q & mwb_fwd_ok & (memwb_rd_q == idex_rn_q) & (idex_rn_q != ZR);
    b_exm = idex_use_rm_q & exm_fwd_ok & (exmem_rd_q == idex_rm_q) & (idex_rm_q != ZR);
    b_mwb = idex_use_rm_q & mwb_fwd_ok & (memwb_rd_q == idex_rm_q) & (idex_rm_q != ZR);

    // EX/MEM holds the younger producer, so it wins over MEM/WB.
    if (a_exm)      fwd_a_sel = SEL_EXM;
    else if (a_mwb) fwd_a_sel = SEL_MWB;
    else            fwd_a_sel = SEL_RF;

    if (idex_use_imm_q) fwd_b_sel = SEL_IMM;
    else if (b_exm)     fwd_b_sel = SEL_EXM;
    else if (b_mwb)     fwd_b_sel = SEL_MWB;
    else                fwd_b_sel = SEL_RF;
  end

  // Next ID/EX contents. A squashed or stalled slot becomes a bubble with
  // every field zeroed, so no stale tag can match later.
  always_comb begin
    take            = id_valid & ~stall & ~flush;
    idex_valid_d    = take;
    idex_rn_d       = take ? id_rn       : '0;
    idex_rm_d       = take ? id_rm       : '0;
    idex_use_rn_d   = take & id_use_rn;
    idex_use_rm_d   = take & id_use_rm;
    idex_use_imm_d  = take & id_use_imm;
    idex_rd_d       = take ? id_rd       : '0;
    idex_regwrite_d = take & id_regwrite;
    idex_memread_d  = take & id_memread;
  end

  // Saturating stall counter: holds at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idex_valid_q     <= 1'b0;
      idex_rn_q        <= '0;
      idex_rm_q        <= '0;
      idex_use_rn_q    <= 1'b0;
      idex_use_rm_q    <= 1'b0;
      idex_use_imm_q   <= 1'b0;
      idex_rd_q        <= '0;
      idex_regwrite_q  <= 1'b0;
      idex_memread_q   <= 1'b0;
      exmem_valid_q    <= 1'b0;
      exmem_rd_q       <= '0;
      exmem_regwrite_q <= 1'b0;
      exmem_memread_q  <= 1'b0;
      memwb_valid_q    <= 1'b0;
      memwb_rd_q       <= '0;
      memwb_regwrite_q <= 1'b0;
      cnt_q            <= '0;
    end else begin
      memwb_valid_q    <= exmem_valid_q;
      memwb_rd_q       <= exmem_rd_q;
      memwb_regwrite_q <= exmem_regwrite_q;

      exmem_valid_q    <= idex_valid_q;
      exmem_rd_q       <= idex_rd_q;
      exmem_regwrite_q <= idex_regwrite_q;
      exmem_memread_q  <= idex_memread_q;

      idex_valid_q     <= idex_valid_d;
      idex_rn_q        <= idex_rn_d;
      idex_rm_q        <= idex_rm_d;
      idex_use_rn_q    <= idex_use_rn_d;
      idex_use_rm_q    <= idex_use_rm_d;
      idex_use_imm_q   <= idex_use_imm_d;
      idex_rd_q        <= idex_rd_d;
      idex_regwrite_q  <= idex_regwrite_d;
      idex_memread_q   <= idex_memread_d;

      cnt_q            <= cnt_d;
    end
  end

  assign stall_count = cnt_q;

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Forwarding and hazard control for the pipelined 64-bit LEGv8 datapath.
- Tracks the register tags of instructions in the ID/EX, EX/MEM and MEM/WB stages.
- Produces the 2-bit select lines for the two EX-stage operand 4:1 muxes, a load-use stall, and a stall-cycle counter.
- Sits directly upstream of the operand muxes: its sel outputs drive them.

Parameters:
REG_W, 5, register index width
ZERO_REG, 31, index of XZR; never forwarded, never a hazard source
CNT_W, 32, width of the stall counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
id_valid  input  1  decode slot holds a real instruction
id_rn  input  REG_W  decode source A register
id_rm  input  REG_W  decode source B register
id_use_rn  input  1  decode instruction reads rn
id_use_rm  input  1  decode instruction reads rm
id_use_imm  input  1  decode instruction takes operand B from the immediate
id_rd  input  REG_W  decode destination register
id_regwrite  input  1  decode instruction writes rd
id_memread  input  1  decode instruction is a load
flush  input  1  branch taken; squash the decode slot
fwd_a_sel  output  2  operand A mux select
fwd_b_sel  output  2  operand B mux select
stall  output  1  hold PC and IF/ID; bubble into ID/EX
stall_count  output  CNT_W  saturating count of stall cycles

Behaviour:
- Internal tag registers:
  - ID/EX: valid, rn, rm, use_rn, use_rm, use_imm, rd, regwrite, memread.
  - EX/MEM: valid, rd, regwrite, memread.
  - MEM/WB: valid, rd, regwrite.
- On reset low (asynchronous): all tag valids 0, all tag fields 0, stall_count 0. Therefore fwd_a_sel=00, fwd_b_sel=00, stall=0 immediately.
- Every rising edge:
  - MEM/WB <= EX/MEM.
  - EX/MEM <= ID/EX (valid, rd, regwrite, memread).
  - ID/EX <= decode inputs with valid = id_valid & ~stall & ~flush. A bubble has all fields zeroed.
- Stall (combinational): stall = id_valid & IDEX.valid & IDEX.memread & IDEX.regwrite & (IDEX.rd != ZERO_REG), AND at least one of:
  - id_use_rn & (id_rn == IDEX.rd)
  - id_use_rm & ~id_use_imm & (id_rm == IDEX.rd)
- Stall duration is exactly one cycle per load-use pair; the bubble removes the condition next cycle.
- flush has priority over stall for the ID/EX update. stall is still reported combinationally when both are high.
- Select encoding, matching the mux input order: 00 register-file data, 01 EX/MEM ALU result, 10 MEM/WB writeback data, 11 immediate (B only).
- fwd_a_sel, combinational from tag registers only:
  - 01 if IDEX.use_rn & EXMEM.valid & EXMEM.regwrite & ~EXMEM.memread & EXMEM.rd==IDEX.rn & IDEX.rn!=ZERO_REG
  - else 10 if the same test passes against MEM/WB (memread is ignored for MEM/WB)
  - else 00
- fwd_b_sel: 11 if IDEX.use_imm; otherwise the same rule applied to rm / use_rm.
- EX/MEM wins over MEM/WB when both match (youngest producer).
- A load in EX/MEM is never forwarded from EX/MEM; the stall guarantees it reaches MEM/WB first.
- Select outputs depend only on registered state; no combinational path from id_* inputs to sel.
- stall_count increments by 1 on each edge where stall=1 and saturates at all-ones (no wrap).

Test Plan:
- Reset pulse mid-run with tags populated -> all outputs 0 asynchronously, before the next clock edge; stall_count=0.
- ADD X1 then SUB X2,X1,X3 back-to-back -> when SUB is in EX: fwd_a_sel=01, fwd_b_sel=00, stall=0.
- ADD X1; NOP; ORR X4,X5,X1 -> when ORR is in EX: fwd_b_sel=10. Then ADD X1; ADD X1; AND X6,X1,X1 -> fwd_a_sel=fwd_b_sel=01 (EX/MEM priority).
- LDUR X7; ADD X8,X7,X9 -> stall=1 for exactly one cycle and stall_count 0->1. Then fwd_a_sel=10 when ADD is in EX.
- LDUR X31 followed by reader of X31, and ADD X31 followed by reader -> stall=0 and sel=00 throughout. ADDI with use_imm=1 -> fwd_b_sel=11 regardless of rm match.
- Load-use with flush=1 in the same cycle -> ID/EX becomes a bubble (next cycle sel=00). Force stall_count to all-ones via a long stall run -> it holds at all-ones.
